// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake bundle.
//   master (fetch_unit): drives out_valid, out_instr, out_pc, out_pc_plus4,
//                        out_misalign; samples out_ready.
//   slave  (decode)    : the mirror image.
interface fetch_unit_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic        out_misalign;

   modport master (
      output out_valid, out_instr, out_pc, out_pc_plus4, out_misalign,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_instr, out_pc, out_pc_plus4, out_misalign,
      output out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the pc, addresses a combinational-read
// instruction memory, and queues {pc, instr, misalign} in a small in-order
// buffer that feeds decode through a valid/ready handshake. A redirect from
// execute flushes the buffer and restarts fetch at the (word-aligned) target.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   imem_addr       byte address to instruction memory (the pc register)
//   imem_instr      word returned for imem_addr in the same cycle
//   redirect_valid  restart request from execute
//   redirect_pc     restart target (low two bits force-aligned away)
//   dec             fetch_unit_if.master handshake toward decode
//   perf_fetched    (FETCH_PERF_CNT_EN only) pushes into the buffer
//   perf_stall      (FETCH_PERF_CNT_EN only) cycles with out_valid && !out_ready
//
// Optional feature macro: FETCH_PERF_CNT_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   output logic [31:0]  imem_addr,
   input  logic [31:0]  imem_instr,
   input  logic         redirect_valid,
   input  logic [31:0]  redirect_pc,
   fetch_unit_if.master dec
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]  perf_fetched,
   output logic [31:0]  perf_stall
`endif
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [31:0]                  pc;
   logic                         mis_flag;
   logic [PW-1:0]                rptr, wptr;
   logic [CW-1:0]                count;
   logic [BUF_DEPTH-1:0][31:0]   buf_pc;
   logic [BUF_DEPTH-1:0][31:0]   buf_instr;
   logic [BUF_DEPTH-1:0]         buf_mis;

   logic valid, full, pop, push;

   assign valid = (count != '0);
   assign full  = (count == CW'(BUF_DEPTH));
   // Redirect kills the head even if decode is taking it this cycle.
   assign pop   = valid && dec.out_ready && !redirect_valid;
   assign push  = !redirect_valid && (!full || pop);

   assign imem_addr = pc;

   // Outputs are zeroed while empty so reset shows all-zero outputs.
   assign dec.out_valid    = valid;
   assign dec.out_pc       = valid ? buf_pc[rptr]          : '0;
   assign dec.out_instr    = valid ? buf_instr[rptr]       : '0;
   assign dec.out_pc_plus4 = valid ? buf_pc[rptr] + 32'd4  : '0;
   assign dec.out_misalign = valid ? buf_mis[rptr]         : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         mis_flag <= 1'b0;
         rptr     <= '0;
         wptr     <= '0;
         count    <= '0;
      end else if (redirect_valid) begin
         pc       <= {redirect_pc[31:2], 2'b00};
         mis_flag <= (redirect_pc[1:0] != 2'b00);
         rptr     <= '0;
         wptr     <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            pc       <= pc + 32'd4;
            mis_flag <= 1'b0;
            wptr     <= wptr + PW'(1);   // power-of-two depth: natural wrap
         end
         if (pop)
            rptr <= rptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: it is only visible while count != 0.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc[wptr]    <= pc;
         buf_instr[wptr] <= imem_instr;
         buf_mis[wptr]   <= mis_flag;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (push)
            perf_fetched <= perf_fetched + 32'd1;
         if (valid && !dec.out_ready)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan steps followed by a randomized
// phase, all checked against a queue-based reference model of the fetch
// stream (entries buffered, fetch pc, misalign marker, perf counts).
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          BUF_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall;
`endif

   fetch_unit_if ifc ();

   fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec            (ifc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   // Instruction memory: 64 words, aliased by address bits [7:2].
   logic [31:0] mem [64];
   assign imem_instr = mem[imem_addr[7:2]];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return mem[a[7:2]];
   endfunction

   // Reference model
   typedef struct { logic [31:0] pc; logic mis; } ent_t;
   ent_t        q[$];
   logic [31:0] fpc;
   logic        fmis;
   logic [31:0] m_fetched, m_stall;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      fpc = RESET_PC;
      fmis = 1'b0;
      m_fetched = '0;
      m_stall = '0;
   endtask

   // One clock: drive inputs, check outputs against model, advance model.
   task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
      bit pop, push;
      ifc.out_ready  = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      chk("imem_addr", imem_addr, fpc);
      chk("out_valid", 32'(ifc.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("out_pc",       ifc.out_pc,        q[0].pc);
         chk("out_instr",    ifc.out_instr,     mem_word(q[0].pc));
         chk("out_pc_plus4", ifc.out_pc_plus4,  q[0].pc + 32'd4);
         chk("out_misalign", 32'(ifc.out_misalign), 32'(q[0].mis));
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall",   perf_stall,   m_stall);
`endif
      pop  = (q.size() != 0) && rdy && !rv;
      push = !rv && ((q.size() < BUF_DEPTH) || pop);
      if ((q.size() != 0) && !rdy) m_stall++;
      @(posedge clk);
      if (rv) begin
         q.delete();
         fpc  = {rpc[31:2], 2'b00};
         fmis = (rpc[1:0] != 2'b00);
      end else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back('{pc: fpc, mis: fmis});
            fpc  = fpc + 32'd4;
            fmis = 1'b0;
            m_fetched++;
         end
      end
      @(negedge clk);
   endtask

   // Asynchronous reset pulse issued mid-cycle; outputs must drop at once.
   task automatic mid_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_out_pc",    ifc.out_pc,        32'd0);
      chk("rst_out_instr", ifc.out_instr,     32'd0);
      chk("rst_imem_addr", imem_addr,         RESET_PC);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_perf_fetched", perf_fetched, 32'd0);
      chk("rst_perf_stall",   perf_stall,   32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0]  = 32'h0050_0093;
      mem[1]  = 32'h00A0_0113;
      mem[13] = 32'h00B6_0463;
      ifc.out_ready = 1'b0;
      model_reset();

      // Reset state
      @(negedge clk);
      chk("reset_valid", 32'(ifc.out_valid), 32'd0);
      chk("reset_addr",  imem_addr, RESET_PC);
      chk("reset_pc4",   ifc.out_pc_plus4, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Streaming at one instruction per cycle
      cycle(1'b1, 1'b0, '0);
      chk("t1_pc0",    ifc.out_pc,       32'h0);
      chk("t1_instr0", ifc.out_instr,    32'h0050_0093);
      chk("t1_pc4_0",  ifc.out_pc_plus4, 32'h4);
      cycle(1'b1, 1'b0, '0);
      chk("t1_pc1",    ifc.out_pc,       32'h4);
      chk("t1_instr1", ifc.out_instr,    32'h00A0_0113);
      repeat (4) cycle(1'b1, 1'b0, '0);

      // Stall fills the buffer, then release
      mid_reset();
      repeat (5) cycle(1'b0, 1'b0, '0);
      chk("t2_hold_addr", imem_addr,  32'h8);
      chk("t2_hold_pc",   ifc.out_pc, 32'h0);
      repeat (4) cycle(1'b1, 1'b0, '0);

      // Redirect with two entries buffered (and head offered to decode)
      repeat (3) cycle(1'b0, 1'b0, '0);
      cycle(1'b1, 1'b1, 32'h34);
      chk("t3_bubble", 32'(ifc.out_valid), 32'd0);
      cycle(1'b1, 1'b0, '0);
      chk("t3_pc",    ifc.out_pc,    32'h34);
      chk("t3_instr", ifc.out_instr, 32'h00B6_0463);
      cycle(1'b1, 1'b0, '0);

      // Misaligned redirect target
      cycle(1'b1, 1'b1, 32'h41);
      cycle(1'b1, 1'b0, '0);
      chk("t4_pc",  ifc.out_pc, 32'h40);
      chk("t4_mis", 32'(ifc.out_misalign), 32'd1);
      cycle(1'b1, 1'b0, '0);
      chk("t4_pc_next",  ifc.out_pc, 32'h44);
      chk("t4_mis_next", 32'(ifc.out_misalign), 32'd0);

      // pc wraparound
      cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
      cycle(1'b1, 1'b0, '0);
      chk("t5_pc",  ifc.out_pc,       32'hFFFF_FFFC);
      chk("t5_pc4", ifc.out_pc_plus4, 32'h0);
      cycle(1'b1, 1'b0, '0);
      chk("t5_wrap", ifc.out_pc, 32'h0);

      // Back-to-back redirects: only the last target is fetched
      cycle(1'b1, 1'b1, 32'h10);
      cycle(1'b1, 1'b1, 32'h20);
      cycle(1'b1, 1'b0, '0);
      chk("t6_last", ifc.out_pc, 32'h20);

      // Reset while full and stalled
      repeat (4) cycle(1'b0, 1'b0, '0);
      mid_reset();
      cycle(1'b1, 1'b0, '0);
      chk("t7_restart", ifc.out_pc, RESET_PC);

      // Randomized phase
      for (int i = 0; i < 400; i++) begin
         logic        rdy, rv;
         logic [31:0] rpc;
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 9) == 0);
         rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC - 32'($urandom_range(0, 3))
                                          : $urandom;
         cycle(rdy, rv, rpc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of the word-addressed, combinational-read instruction memory.
- Owns the program counter and drives the memory address.
- Captures the returned word into a small in-order buffer and presents {pc, instr} to decode with a valid/ready handshake.
- Accepts a redirect (branch/jump target) from execute, which flushes the buffer and restarts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- BUF_DEPTH, 2, fetch buffer entries; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals the pc register.
- imem_instr  input  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  input  1  execute requests a fetch restart this cycle.
- redirect_pc  input  32  restart target; sampled when redirect_valid=1.
- out_valid  output  1  buffer head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  head instruction word.
- out_pc  output  32  byte address of out_instr.
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
- out_misalign  output  1  head entry was fetched from a force-aligned misaligned redirect target.

Behaviour:
- Reset (async, any time, including mid-flush or mid-handshake):
  - pc = RESET_PC; buffer count = 0; read/write pointers = 0; misalign flag = 0.
  - out_valid = 0; out_instr, out_pc, out_pc_plus4 = 0; out_misalign = 0.
- imem_addr = pc (pure register output, no combinational path from any input).
- pop = out_valid && out_ready.
- push = !redirect_valid && (count < BUF_DEPTH || pop).
  - Push writes {pc, imem_instr, misalign_flag} at the write pointer; then pc <= pc + 4 (wraps 32'hFFFF_FFFC -> 0) and misalign_flag <= 0.
- Buffer full with no pop: no push; pc holds; imem_addr stable.
- Buffer full with pop in the same cycle: push and pop both occur; count unchanged.
- Count update: count += push - pop. Pointers wrap modulo BUF_DEPTH.
- Outputs come from the head entry. out_valid = (count != 0). out_* hold stable while out_valid && !out_ready.
- Redirect has highest priority:
  - Buffer flushed (count = 0; read pointer = write pointer = 0); pop and push both suppressed.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - misalign_flag <= (redirect_pc[1:0] != 0).
- Redirect latency: redirect sampled at edge N; out_valid = 0 during cycle N+1; target pushed at edge N+1; out_valid = 1 from cycle N+2. Exactly one bubble cycle.
- Redirect with out_valid && out_ready in the same cycle: the head is NOT considered consumed. Decode/execute kill it, since execute is redirecting.
- Back-to-back redirects: each newer one wins; only the last target is fetched.
- First valid output after reset release: RESET_PC's word, visible the cycle after the first rising edge with rst low.
- Throughput: 1 instruction/cycle while out_ready is held high.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] (increments on each push) and perf_stall[31:0] (increments each cycle out_valid && !out_ready).
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, out_ready=1, memory word0=0x00500093, word1=0x00A00113 -> cycle 1: out_pc=0, out_instr=0x00500093, out_pc_plus4=4; cycle 2: out_pc=4, out_instr=0x00A00113; one instruction per cycle.
- out_ready=0 for 5 cycles after reset -> count reaches BUF_DEPTH=2; imem_addr holds 0x8; out_pc=0 stays stable; on release, pcs 0, 4, 8 appear in order with no gap or duplicate.
- redirect_valid=1, redirect_pc=0x34 while 2 entries are buffered -> next cycle out_valid=0; following cycle out_pc=0x34, out_instr=mem[13]=0x00B60463; stale entries 0x8/0xC never appear.
- redirect_pc=0x41 -> entry out_pc=0x40 with out_misalign=1; the next entry (0x44) has out_misalign=0.
- Redirect to 0xFFFFFFFC with out_ready=1 -> out_pc 0xFFFFFFFC with out_pc_plus4=0; next out_pc=0x0.
- Assert rst for one cycle while full and mid-stall -> out_valid=0 immediately (asynchronously); restart at RESET_PC. With FETCH_PERF_CNT_EN: counters read 0.
